// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared types and constants for the watch mode sequencer
package watch_pkg;

  // Top-level controller state: plain display or field edit
  typedef enum logic {
    DISP = 1'b0,
    EDIT = 1'b1
  } fsm_e;

  localparam int STATE_W = 3;
  localparam int FIELD_W = 2;

  // Display mode indices
  localparam logic [STATE_W-1:0] MODE_TIME = 3'd0;
  localparam logic [STATE_W-1:0] MODE_1    = 3'd1;
  localparam logic [STATE_W-1:0] MODE_2    = 3'd2;
  localparam logic [STATE_W-1:0] MODE_3    = 3'd3;
  localparam logic [STATE_W-1:0] MODE_4    = 3'd4;
  localparam logic [STATE_W-1:0] MODE_5    = 3'd5;
  localparam logic [STATE_W-1:0] MODE_6    = 3'd6;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser, debouncer and press-edge pulse
module key_debounce #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic key,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          level_d1;
  logic [CW-1:0] cnt_q;

  // Two-flop synchroniser for the asynchronous key pin
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], key};
  end

  // Accept the new level only after it has been stable for DEB_CYCLES cycles
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync_q[1];
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // One-cycle pulse on accepted 0->1; release is silent
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      level_d1 <= 1'b0;
      press    <= 1'b0;
    end else begin
      level_d1 <= level_q;
      press    <= level_q & ~level_d1;
    end
  end

endmodule

// File: rtl/watch_mode_sequencer.sv
// rtl/watch_mode_sequencer.sv - display mode / edit field sequencer with debounced keys
module watch_mode_sequencer
  import watch_pkg::*;
#(
  parameter int DEB_CYCLES  = 20000,
  parameter int NUM_MODES   = 7,
  parameter int NUM_FIELDS  = 3,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               mode_key,
  input  logic               set_key,
  input  logic               inc_key,
  output logic [STATE_W-1:0] state,
  output logic               edit,
  output logic [FIELD_W-1:0] field,
  output logic               inc_pulse,
  output logic               mode_chg
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [STATE_W-1:0] LAST_MODE  = STATE_W'(NUM_MODES - 1);
  localparam logic [FIELD_W-1:0] LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);
  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  logic mode_ev, set_ev, inc_ev;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_d;
  logic [FIELD_W-1:0] field_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               inc_d, chg_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk(clk), .clr_n(clr_n), .key(mode_key), .press(mode_ev)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
    .clk(clk), .clr_n(clr_n), .key(set_key), .press(set_ev)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
    .clk(clk), .clr_n(clr_n), .key(inc_key), .press(inc_ev)
  );

  assign edit = (fsm_q == EDIT);

  // Register FSM state, mode, field, timeout timer and output strobes
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fsm_q     <= DISP;
      state     <= MODE_TIME;
      field     <= '0;
      timer_q   <= '0;
      inc_pulse <= 1'b0;
      mode_chg  <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state     <= state_d;
      field     <= field_d;
      timer_q   <= timer_d;
      inc_pulse <= inc_d;
      mode_chg  <= chg_d;
    end
  end

  // Next-state logic; key priority mode > set > inc, key events beat timeout
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state;
    field_d = field;
    timer_d = timer_q;
    inc_d   = 1'b0;
    chg_d   = 1'b0;
    case (fsm_q)
      DISP: begin
        timer_d = '0;
        if (mode_ev) begin
          state_d = (state == LAST_MODE) ? MODE_TIME : state + STATE_W'(1);
          chg_d   = 1'b1;
        end else if (set_ev) begin
          fsm_d   = EDIT;
          field_d = '0;
        end
      end
      EDIT: begin
        if (mode_ev) begin
          // Abort edit without advancing the displayed mode
          fsm_d   = DISP;
          field_d = '0;
          timer_d = '0;
        end else if (set_ev) begin
          timer_d = '0;
          if (field == LAST_FIELD) begin
            fsm_d   = DISP;
            field_d = '0;
          end else begin
            field_d = field + FIELD_W'(1);
          end
        end else if (inc_ev) begin
          inc_d   = 1'b1;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          fsm_d   = DISP;
          field_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        fsm_d   = DISP;
        field_d = '0;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_watch_mode_sequencer.sv
// tb/tb_watch_mode_sequencer.sv - scoreboard bench for watch_mode_sequencer
module tb_watch_mode_sequencer;

  localparam int DEB  = 4;
  localparam int NM   = 7;
  localparam int NF   = 3;
  localparam int TOUT = 50;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       mode_key = 1'b0, set_key = 1'b0, inc_key = 1'b0;
  logic [2:0] state;
  logic       edit;
  logic [1:0] field;
  logic       inc_pulse, mode_chg;

  typedef struct {
    int st;
    int ed;
    int fld;
    int inc;
    int chg;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model of the user-visible state
  int m_state = 0, m_edit = 0, m_field = 0;

  watch_mode_sequencer #(
    .DEB_CYCLES(DEB), .NUM_MODES(NM), .NUM_FIELDS(NF), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .clr_n(clr_n), .mode_key(mode_key), .set_key(set_key),
    .inc_key(inc_key), .state(state), .edit(edit), .field(field),
    .inc_pulse(inc_pulse), .mode_chg(mode_chg)
  );

  always #5 clk = ~clk;

  function automatic void push(input int inc, input int chg);
    txn_t t;
    t.st = m_state; t.ed = m_edit; t.fld = m_field; t.inc = inc; t.chg = chg;
    exp_q.push_back(t);
  endfunction

  // One accepted key event (possibly several keys at once)
  function automatic void model_event(input bit m, input bit s, input bit i);
    if (m_edit != 0) begin
      if (m) begin
        m_edit = 0; m_field = 0; push(0, 0);
      end else if (s) begin
        if (m_field == NF - 1) begin m_edit = 0; m_field = 0; end
        else m_field = m_field + 1;
        push(0, 0);
      end else if (i) begin
        push(1, 0);
      end
    end else begin
      if (m) begin
        m_state = (m_state + 1) % NM; push(0, 1);
      end else if (s) begin
        m_edit = 1; m_field = 0; push(0, 0);
      end
    end
  endfunction

  task automatic press(input bit m, input bit s, input bit i);
    model_event(m, s, i);
    @(negedge clk);
    mode_key = m; set_key = s; inc_key = i;
    repeat (10) @(negedge clk);
    mode_key = 0; set_key = 0; inc_key = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle_timeout();
    if (m_edit != 0) begin
      m_edit = 0; m_field = 0; push(0, 0);
    end
    repeat (TOUT + 10) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every strobe or change of state/edit/field is one transaction
  logic [5:0] prev_steady = '0;
  always @(negedge clk) begin
    if (!clr_n) begin
      prev_steady = '0;
    end else begin
      if (inc_pulse || mode_chg || ({state, edit, field} != prev_steady)) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_txn: got st=%0d ed=%0d fld=%0d inc=%0d chg=%0d, expected none",
                   state, edit, field, inc_pulse, mode_chg);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          if (int'(state) != e.st || int'(edit) != e.ed || int'(field) != e.fld ||
              int'(inc_pulse) != e.inc || int'(mode_chg) != e.chg) begin
            fails++;
            $display("FAIL txn: got st=%0d ed=%0d fld=%0d inc=%0d chg=%0d, expected st=%0d ed=%0d fld=%0d inc=%0d chg=%0d",
                     state, edit, field, inc_pulse, mode_chg, e.st, e.ed, e.fld, e.inc, e.chg);
          end
        end
      end
      prev_steady = {state, edit, field};
    end
  end

  initial begin
    int r;
    bit m, s, i;
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_edit", int'(edit), 0);
    check("reset_field", int'(field), 0);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);

    // Wrap: seven mode presses 1..6,0
    repeat (7) press(1, 0, 0);
    check("wrap_state", int'(state), 0);

    // Bounce: toggling every 2 cycles is never accepted, then one clean press
    model_event(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      mode_key = ~k[0];
      repeat (2) @(negedge clk);
    end
    mode_key = 1'b1;
    repeat (10) @(negedge clk);
    mode_key = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_state", int'(state), 1);

    // Edit walk
    press(0, 1, 0); press(0, 0, 1); press(0, 0, 1);
    press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
    check("walk_edit", int'(edit), 0);
    check("walk_state", int'(state), 1);

    // Abort and timeout
    press(0, 1, 0); press(1, 0, 0);
    check("abort_state", int'(state), 1);
    press(0, 1, 0); press(0, 1, 0);
    idle_timeout();
    check("timeout_edit", int'(edit), 0);
    check("timeout_field", int'(field), 0);

    // Priority and inc in display mode
    press(1, 1, 0);
    check("prio_edit", int'(edit), 0);
    press(0, 0, 1);
    press(1, 1, 1);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      press(1, 0, 0);
      else if (r <= 5) press(0, 1, 0);
      else if (r <= 7) press(0, 0, 1);
      else if (r == 8) begin
        m = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); i = 1'($urandom_range(0, 1));
        press(m, s, i);
      end else idle_timeout();
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end

    // Asynchronous reset mid-edit at state 4
    idle_timeout();
    while (m_state != 4) press(1, 0, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    check("pre_reset_queue", exp_q.size(), 0);
    #2 clr_n = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_edit", int'(edit), 0);
    check("async_field", int'(field), 0);
    check("async_inc", int'(inc_pulse), 0);
    check("async_chg", int'(mode_chg), 0);
    m_state = 0; m_edit = 0; m_field = 0;
    exp_q.delete();

    // Key held through reset release must be re-accepted
    mode_key = 1'b1;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    model_event(1, 0, 0);
    @(negedge clk);
    check("held_not_yet", int'(state), 0);
    repeat (12) @(negedge clk);
    mode_key = 1'b0;
    repeat (10) @(negedge clk);
    check("held_state", int'(state), 1);

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
